// File: rtl/wb_stage_pkg.sv
// Shared types for the writeback stage and its load-alignment helper.
package wb_stage_pkg;

    typedef enum logic [1:0] {
        ALU  = 2'd0,
        LOAD = 2'd1,
        PC4  = 2'd2,
        RSVD = 2'd3
    } rd_data_sel_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } data_width_t;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Extracts and extends a byte/half/word lane from a word-aligned read.
module wb_stage_load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  width_i,
    input  logic        sign_extend_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (offset_i)
            2'd0:    b = rdata_i[7:0];
            2'd1:    b = rdata_i[15:8];
            2'd2:    b = rdata_i[23:16];
            default: b = rdata_i[31:24];
        endcase
        // Half-word bit 0 is ignored; misalignment never reaches here.
        h = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o = rdata_i;
        unique case (1'b1)
            (width_i == BYTE): data_o = {{24{sign_extend_i & b[7]}}, b};
            (width_i == HALF): data_o = {{16{sign_extend_i & h[15]}}, h};
            default:           data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32E writeback: data select, load-response wait with timeout,
// register-file write, decode bypass register and instret counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned INSTRET_WIDTH  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              pc4_WB,
    input  logic [3:0]               rd_WB,
    input  logic [31:0]              alu_result_WB,
    input  logic                     regfile_we_WB,
    input  logic [1:0]               rd_data_sel_WB,
    input  logic                     lsu_sign_extend_WB,
    input  logic [1:0]               data_width_WB,
    input  logic                     invalid_WB,
    input  logic [31:0]              dmem_rdata,
    input  logic                     dmem_rvalid,
    output logic                     rf_we,
    output logic [3:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     stall_WB,
    output logic                     fwd_valid,
    output logic [3:0]               fwd_rd,
    output logic [31:0]              fwd_data,
    output logic                     load_fault,
    output logic                     spurious_rvalid,
    output logic [INSTRET_WIDTH-1:0] instret
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    wb_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic spur_q, spur_d;
    logic fwd_valid_q;
    logic [3:0] fwd_rd_q;
    logic [31:0] fwd_data_q;
    logic [INSTRET_WIDTH-1:0] instret_q;

    logic [31:0] load_data;
    logic is_load;
    logic data_ready;

    wb_stage_load_align u_align (
        .rdata_i       (dmem_rdata),
        .offset_i      (alu_result_WB[1:0]),
        .width_i       (data_width_WB),
        .sign_extend_i (lsu_sign_extend_WB),
        .data_o        (load_data)
    );

    assign is_load    = !invalid_WB && (rd_data_sel_WB == LOAD);
    assign data_ready = is_load ? dmem_rvalid : 1'b1;

    always_comb begin
        rf_wdata = 32'd0;
        unique case (rd_data_sel_WB)
            ALU:     rf_wdata = alu_result_WB;
            LOAD:    rf_wdata = load_data;
            PC4:     rf_wdata = pc4_WB;
            default: rf_wdata = 32'd0;
        endcase
    end

    assign rf_we = regfile_we_WB && !invalid_WB && (rd_WB != 4'd0)
                && (rd_data_sel_WB != RSVD) && data_ready;
    assign rf_waddr = rd_WB;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        spur_d     = spur_q;
        stall_WB   = 1'b0;
        load_fault = 1'b0;
        unique case (state_q)
            RUN: begin
                if (is_load && !dmem_rvalid) begin
                    stall_WB = 1'b1;
                    state_d  = WAIT;
                    cnt_d    = CW'(1);
                end else if (!is_load && dmem_rvalid) begin
                    spur_d = 1'b1;
                end
            end
            WAIT: begin
                // A response on the timeout cycle still completes normally.
                if (dmem_rvalid) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    load_fault = 1'b1;
                    state_d    = RUN;
                    cnt_d      = '0;
                end else begin
                    stall_WB = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            spur_q      <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_rd_q    <= 4'd0;
            fwd_data_q  <= 32'd0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            spur_q      <= spur_d;
            fwd_valid_q <= rf_we;
            if (rf_we) begin
                fwd_rd_q   <= rf_waddr;
                fwd_data_q <= rf_wdata;
            end
            if (!invalid_WB && !stall_WB) begin
                instret_q <= instret_q + INSTRET_WIDTH'(1);
            end
        end
    end

    assign fwd_valid       = fwd_valid_q;
    assign fwd_rd          = fwd_rd_q;
    assign fwd_data        = fwd_data_q;
    assign spurious_rvalid = spur_q;
    assign instret         = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a cycle-level behavioural model.
module tb_wb_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc4 = 32'd0;
    logic [3:0]  rd = 4'd0;
    logic [31:0] alu = 32'd0;
    logic        we = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        sx = 1'b0;
    logic [1:0]  wid = 2'd0;
    logic        inv = 1'b1;
    logic [31:0] rdata = 32'd0;
    logic        rvalid = 1'b0;

    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall;
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        load_fault;
    logic        spur;
    logic [63:0] instret;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    wb_stage #(.TIMEOUT_CYCLES(TO), .INSTRET_WIDTH(64)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pc4_WB             (pc4),
        .rd_WB              (rd),
        .alu_result_WB      (alu),
        .regfile_we_WB      (we),
        .rd_data_sel_WB     (sel),
        .lsu_sign_extend_WB (sx),
        .data_width_WB      (wid),
        .invalid_WB         (inv),
        .dmem_rdata         (rdata),
        .dmem_rvalid        (rvalid),
        .rf_we              (rf_we),
        .rf_waddr           (rf_waddr),
        .rf_wdata           (rf_wdata),
        .stall_WB           (stall),
        .fwd_valid          (fwd_valid),
        .fwd_rd             (fwd_rd),
        .fwd_data           (fwd_data),
        .load_fault         (load_fault),
        .spurious_rvalid    (spur),
        .instret            (instret)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [31:0] fmt(input logic [31:0] d,
                                        input logic [1:0] off,
                                        input logic [1:0] w,
                                        input logic s);
        logic [31:0] v;
        if (w == 2'd0) begin
            v = (d >> (int'(off) * 8)) & 32'hFF;
            if (s && v[7]) v = v | 32'hFFFF_FF00;
        end else if (w == 2'd1) begin
            v = (d >> (off[1] ? 16 : 0)) & 32'hFFFF;
            if (s && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // Model state: cycles already spent waiting for the outstanding load.
    int          m_waited = 0;
    bit          m_spur = 0;
    bit          m_fv = 0;
    logic [3:0]  m_frd = 0;
    logic [31:0] m_fdata = 0;
    logic [63:0] m_inst = 0;

    always @(negedge clk) begin
        bit ld, tmo, e_stall, e_we;
        logic [31:0] e_data;
        if (!rst_n) begin
            m_waited = 0; m_spur = 0; m_fv = 0;
            m_frd = 0; m_fdata = 0; m_inst = 0;
        end
        ld = !inv && sel == 2'd1;
        tmo = ld && !rvalid && m_waited == TO;
        e_stall = ld && !rvalid && !tmo;
        e_we = we && !inv && rd != 0 && sel != 2'd3 && (!ld || rvalid);
        case (sel)
            2'd0: e_data = alu;
            2'd1: e_data = fmt(rdata, alu[1:0], wid, sx);
            2'd2: e_data = pc4;
            default: e_data = 32'd0;
        endcase
        chk("rf_we", 64'(rf_we), 64'(e_we));
        chk("rf_waddr", 64'(rf_waddr), 64'(rd));
        chk("rf_wdata", 64'(rf_wdata), 64'(e_data));
        chk("stall", 64'(stall), 64'(e_stall));
        chk("fault", 64'(load_fault), 64'(tmo));
        chk("fwd_valid", 64'(fwd_valid), 64'(m_fv));
        chk("fwd_rd", 64'(fwd_rd), 64'(m_frd));
        chk("fwd_data", 64'(fwd_data), 64'(m_fdata));
        chk("spurious", 64'(spur), 64'(m_spur));
        chk("instret", instret, m_inst);
        if (rst_n) begin
            if (!ld && rvalid) m_spur = 1;
            m_waited = e_stall ? m_waited + 1 : 0;
            if (!inv && !e_stall) m_inst = m_inst + 1;
            m_fv = e_we;
            if (e_we) begin
                m_frd = rd;
                m_fdata = e_data;
            end
        end
    end

    task automatic drv(input bit i_inv, input bit i_we, input logic [3:0] i_rd,
                       input logic [1:0] i_sel, input logic [1:0] i_w,
                       input bit i_sx, input logic [31:0] i_alu,
                       input logic [31:0] i_pc4, input logic [31:0] i_rdata,
                       input bit i_rv);
        @(posedge clk);
        #1;
        inv = i_inv; we = i_we; rd = i_rd; sel = i_sel; wid = i_w;
        sx = i_sx; alu = i_alu; pc4 = i_pc4; rdata = i_rdata; rvalid = i_rv;
        #1;
    endtask

    task automatic bubble(input bit i_rv);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, i_rv);
    endtask

    initial begin
        #2;
        chk("lit_reset_instret", instret, 64'd0);
        chk("lit_reset_fwd", 64'(fwd_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        drv(0, 1, 5, 0, 0, 0, 32'h1234_5678, 32'h100, 0, 0);
        chk("lit_alu_we", 64'(rf_we), 64'd1);
        chk("lit_alu_data", 64'(rf_wdata), 64'h1234_5678);
        bubble(0);
        chk("lit_fwd_valid", 64'(fwd_valid), 64'd1);
        chk("lit_fwd_data", 64'(fwd_data), 64'h1234_5678);
        chk("lit_instret1", instret, 64'd1);

        drv(0, 1, 6, 1, 0, 1, 32'h0000_1003, 0, 32'h80FF_0000, 1);
        chk("lit_lb_data", 64'(rf_wdata), 64'hFFFF_FF80);
        chk("lit_lb_stall", 64'(stall), 64'd0);
        drv(0, 1, 6, 1, 1, 0, 32'h0000_1002, 0, 32'h80FF_0000, 1);
        chk("lit_lhu_data", 64'(rf_wdata), 64'h0000_80FF);

        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 7, 1, 2, 0, 32'h2000, 0, 32'h0, 0);
            chk("lit_lw_stall", 64'(stall), 64'd1);
        end
        drv(0, 1, 7, 1, 2, 0, 32'h2000, 0, 32'hDEAD_BEEF, 1);
        chk("lit_lw_data", 64'(rf_wdata), 64'hDEAD_BEEF);
        chk("lit_lw_stall_end", 64'(stall), 64'd0);
        bubble(0);
        chk("lit_instret4", instret, 64'd4);

        for (int i = 0; i < TO; i++) drv(0, 1, 8, 1, 2, 0, 32'h3000, 0, 0, 0);
        drv(0, 1, 8, 1, 2, 0, 32'h3000, 0, 0, 0);
        chk("lit_fault", 64'(load_fault), 64'd1);
        chk("lit_fault_we", 64'(rf_we), 64'd0);
        bubble(0);

        drv(0, 1, 0, 0, 0, 0, 32'h55, 0, 0, 0);
        chk("lit_x0_we", 64'(rf_we), 64'd0);
        drv(1, 1, 3, 0, 0, 0, 32'h66, 0, 0, 0);
        chk("lit_inv_we", 64'(rf_we), 64'd0);
        drv(0, 1, 9, 2, 0, 0, 32'h77, 32'h104, 0, 0);
        chk("lit_pc4", 64'(rf_wdata), 64'h104);
        drv(0, 1, 10, 3, 0, 0, 32'h88, 32'h108, 0, 0);
        chk("lit_rsvd_we", 64'(rf_we), 64'd0);
        bubble(0);
        chk("lit_instret8", instret, 64'd8);

        drv(0, 1, 11, 1, 2, 0, 32'h4000, 0, 0, 0);
        drv(0, 1, 11, 1, 2, 0, 32'h4000, 0, 0, 0);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        inv = 1; we = 0; sel = 0; rd = 0; rvalid = 1; rdata = 32'h1;
        #1;
        chk("lit_rst_stall", 64'(stall), 64'd0);
        chk("lit_rst_we", 64'(rf_we), 64'd0);
        chk("lit_rst_instret", instret, 64'd0);
        bubble(0);
        chk("lit_spurious", 64'(spur), 64'd1);
        bubble(0);
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RV32E pipeline, directly downstream of the MEMEX/WB pipeline register.
- Selects the destination data for each instruction: ALU result, aligned and extended load data, or PC+4.
- Waits for the data-memory read response, stalling the pipeline while a load is outstanding.
- Drives the register-file write port, a one-cycle-delayed bypass register for decode, and the retired-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before a load fault is declared (must be ≥1).
- INSTRET_WIDTH, 64: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc4_WB  in  32  PC+4 of the WB instruction
- rd_WB  in  4  destination register (x0..x15)
- alu_result_WB  in  32  ALU result; for loads, the byte address (bits [1:0] = offset)
- regfile_we_WB  in  1  write enable (already cleared by the register for invalid slots)
- rd_data_sel_WB  in  2  0=ALU, 1=LOAD, 2=PC4, 3=reserved
- lsu_sign_extend_WB  in  1  1=sign-extend load data, 0=zero-extend
- data_width_WB  in  2  0=byte, 1=half, 2=word, 3=treated as word
- invalid_WB  in  1  bubble/flushed slot
- dmem_rdata  in  32  memory read data, word-aligned
- dmem_rvalid  in  1  single-cycle pulse, one per issued load
- rf_we  out  1  register-file write enable
- rf_waddr  out  4  register-file write address
- rf_wdata  out  32  register-file write data
- stall_WB  out  1  hold the pipeline (hazard unit freezes IF..MEMEX/WB)
- fwd_valid  out  1  registered copy of the last committed write is valid
- fwd_rd  out  4  registered last write address
- fwd_data  out  32  registered last write data
- load_fault  out  1  one-cycle pulse on load timeout
- spurious_rvalid  out  1  sticky flag: rvalid seen with no load pending
- instret  out  INSTRET_WIDTH  retired-instruction count

Behaviour:
- Reset (async, rst_n=0):
  - FSM enters RUN; the timeout counter clears.
  - fwd_valid=0, fwd_rd=0, fwd_data=0, load_fault=0, spurious_rvalid=0, instret=0.
  - Combinational outputs settle with FSM=RUN.
- Definition: is_load = !invalid_WB && rd_data_sel_WB==1. A load to x0 still consumes its response.
- Load data formatting:
  - Byte: byte lane alu_result_WB[1:0].
  - Half: lane alu_result_WB[1]; bit 0 is ignored (misalignment is trapped upstream).
  - Word: the full word.
  - Extension per lsu_sign_extend_WB.
- Data select:
  - 0 → alu_result_WB.
  - 1 → formatted dmem_rdata.
  - 2 → pc4_WB.
  - 3 → 0, and write suppressed.
- rf_we = regfile_we_WB && !invalid_WB && rd_WB!=0 && sel!=3 && data_ready.
  - data_ready = 1 for non-loads; for loads, data_ready = dmem_rvalid.
  - rf_waddr = rd_WB and rf_wdata = selected data at all times.
- FSM RUN:
  - is_load && dmem_rvalid: complete in the same cycle with zero stall; stay in RUN.
  - is_load && !dmem_rvalid: stall_WB=1, rf_we=0, go to WAIT, counter←1.
  - !is_load && dmem_rvalid: set spurious_rvalid (sticky until reset); no write caused.
- FSM WAIT:
  - stall_WB=1 while dmem_rvalid=0; inputs are held stable by the freeze.
  - On dmem_rvalid: write as in RUN, stall_WB=0, go to RUN.
  - If counter==TIMEOUT_CYCLES and no rvalid: load_fault pulses for 1 cycle, stall_WB=0, no write, go to RUN.
  - Otherwise the counter increments.
  - An rvalid arriving exactly on the timeout cycle wins: normal completion, no fault.
- Completion: a cycle with !invalid_WB && !stall_WB.
  - instret increments by 1 on completion, including faulted loads and x0 writes.
  - instret wraps modulo 2^INSTRET_WIDTH.
- Bypass register: at each clock edge, fwd_valid←rf_we; if rf_we, also fwd_rd←rf_waddr and fwd_data←rf_wdata. fwd_rd and fwd_data otherwise hold.
- Reset asserted in WAIT abandons the load. A later rvalid then sets spurious_rvalid.

Decomposition:
- Shared package entries:
  - Enum rd_data_sel_t: ALU, LOAD, PC4, RSVD.
  - Enum data_width_t: BYTE, HALF, WORD.
  - Enum wb_state_t: RUN, WAIT.
- Sub-module: a purely combinational load_align (inputs rdata, offset, width, sign_extend; output 32-bit data), reusable by a future LSU.

Test Plan:
- ALU op, rd=5, alu=0x1234_5678 → rf_we=1, waddr=5, wdata=0x12345678, stall=0; next cycle fwd_valid=1, fwd_data=0x12345678; instret +1.
- LB, offset 3, sign=1, rdata=0x80FF_0000, rvalid same cycle → wdata=0xFFFF_FF80, stall never asserted. LHU, offset 2, same rdata → 0x0000_80FF.
- LW with rvalid 3 cycles late, rdata=0xDEAD_BEEF → stall_WB=1 for exactly 3 cycles, single write 0xDEADBEEF in the rvalid cycle; instret +1 only.
- Load, TIMEOUT_CYCLES=4, no rvalid → stall 4 cycles, load_fault pulses once, no write, FSM back in RUN.
- rd=0 ALU op with we=1, and invalid_WB=1 with we=1 → rf_we=0 in both; instret +1 for the rd=0 op and +0 for the invalid slot.
- rst_n pulsed low mid-WAIT, then rvalid → FSM RUN, stall=0, instret=0, spurious_rvalid=1, no write.
